lb4_down_timer: RTL and testbench

- Cascadable down-counting timer slice. It is the borrow-chain counterpart of our carry-chain up/down counter slices.
- It accepts a preload value through a valid/ready handshake and decrements while enabled by a borrow-in.
- It emits borrow-out to the next slice and a terminal-count pulse when the whole chain reaches zero.
- It is used to build programmable interval timers from N slices with a shared chain-expire net.

---
 rtl/lb4_down_timer.sv | 83 ++++++++
 tb/tb_lb4_down_timer.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lb4_down_timer.sv
// lb4_down_timer: cascadable down-counting timer slice with preload handshake and borrow chain.
// Define LB_DOWN_TIMER_AUTORELOAD_EN to reload from RLD on expiry instead of stopping in EXPIRED.
module lb4_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             CK,
    input  logic             SR,
    input  logic             LD_VALID,
    output logic             LD_READY,
    input  logic [WIDTH-1:0] LD_DATA,
    input  logic             START,
    input  logic             STOP,
    input  logic             SP,
    input  logic             BI,
    output logic             BO,
    input  logic             TCI,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, EXPIRED} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic tc_q, tc_d;
    logic ld_fire, dec, exp_ev;
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
    logic [WIDTH-1:0] rld_q, rld_d;
`endif
    assign BUSY     = state_q == RUN;
    assign LD_READY = state_q != RUN;
    assign ld_fire  = LD_VALID & LD_READY;
    assign dec      = BUSY & SP & BI & ~STOP;
    assign BO       = dec & (q_q == '0);
    // TCI is the MSB slice's BO, so every slice sees exp_ev together
    assign exp_ev   = dec & TCI;
    assign Q        = q_q;
    assign TC       = tc_q;
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        tc_d    = exp_ev;
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
        rld_d   = rld_q;
`endif
        if (ld_fire) begin
            q_d     = LD_DATA;
            state_d = ARMED;
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
            rld_d   = LD_DATA;
`endif
        end else if (state_q == ARMED && START) begin
            state_d = RUN;
        end else if (state_q == RUN && STOP) begin
            state_d = ARMED;
        end else if (exp_ev) begin
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
            q_d     = rld_q;
`else
            q_d     = '0;
            state_d = EXPIRED;
`endif
        end else if (dec) begin
            q_d     = q_q - WIDTH'(1);
        end
    end
    always_ff @(posedge CK) begin
        if (SR) begin
            state_q <= IDLE;
            q_q     <= '0;
            tc_q    <= 1'b0;
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
            rld_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            tc_q    <= tc_d;
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
            rld_q   <= rld_d;
`endif
        end
    end
endmodule

// File: tb/tb_lb4_down_timer.sv
// tb_lb4_down_timer: directed checks of a single slice and a two-slice chain.
module tb_lb4_down_timer;
    logic ck = 1'b0;
    logic sr;
    logic a_ldv, a_start, a_stop, a_sp, a_ldr, a_bo, a_tc, a_busy;
    logic [3:0] a_ldd, a_q;
    logic c_ldv, c_start, c_stop, c_sp;
    logic [3:0] lo_ldd, hi_ldd, lo_q, hi_q;
    logic lo_ldr, lo_bo, lo_tc, lo_busy, hi_ldr, hi_bo, hi_tc, hi_busy;
    int checks = 0;
    int failures = 0;
    int n;
    always #5 ck = ~ck;
    lb4_down_timer #(.WIDTH(4)) u_a (
        .CK(ck), .SR(sr), .LD_VALID(a_ldv), .LD_READY(a_ldr), .LD_DATA(a_ldd),
        .START(a_start), .STOP(a_stop), .SP(a_sp), .BI(1'b1), .BO(a_bo),
        .TCI(a_bo), .Q(a_q), .TC(a_tc), .BUSY(a_busy)
    );
    lb4_down_timer #(.WIDTH(4)) u_lo (
        .CK(ck), .SR(sr), .LD_VALID(c_ldv), .LD_READY(lo_ldr), .LD_DATA(lo_ldd),
        .START(c_start), .STOP(c_stop), .SP(c_sp), .BI(1'b1), .BO(lo_bo),
        .TCI(hi_bo), .Q(lo_q), .TC(lo_tc), .BUSY(lo_busy)
    );
    lb4_down_timer #(.WIDTH(4)) u_hi (
        .CK(ck), .SR(sr), .LD_VALID(c_ldv), .LD_READY(hi_ldr), .LD_DATA(hi_ldd),
        .START(c_start), .STOP(c_stop), .SP(c_sp), .BI(lo_bo), .BO(hi_bo),
        .TCI(hi_bo), .Q(hi_q), .TC(hi_tc), .BUSY(hi_busy)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge ck);
        #1;
    endtask
    initial begin
        sr = 1; a_ldv = 0; a_start = 0; a_stop = 0; a_sp = 1; a_ldd = 0;
        c_ldv = 0; c_start = 0; c_stop = 0; c_sp = 1; lo_ldd = 0; hi_ldd = 0;
        step(); step(); sr = 0; #1;
        check("rst_q", a_q, 0);
        check("rst_tc", a_tc, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ldr", a_ldr, 1);
        check("rst_bo", a_bo, 0);
        a_start = 1; step(); a_start = 0; #1;
        check("idle_start", a_busy, 0);
        a_ldv = 1; a_ldd = 5; step(); #1;
        check("ld_q", a_q, 5);
        a_ldd = 3; a_start = 1; step(); a_ldv = 0; a_start = 0; #1;
        check("ldstart_q", a_q, 3);
        check("ldstart_busy", a_busy, 0);
        a_start = 1; step(); a_start = 0; #1;
        check("run_q", a_q, 3);
        check("run_busy", a_busy, 1);
        check("run_ldr", a_ldr, 0);
        step(); check("dec_q2", a_q, 2);
        step(); check("dec_q1", a_q, 1);
        step(); check("dec_q0", a_q, 0);
        check("zero_bo", a_bo, 1);
        step();
        check("exp_tc", a_tc, 1);
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
        check("exp_reload_q", a_q, 3);
        check("exp_busy", a_busy, 1);
`else
        check("exp_q", a_q, 0);
        check("exp_busy", a_busy, 0);
        check("exp_ldr", a_ldr, 1);
        check("exp_bo", a_bo, 0);
        a_start = 1; step(); a_start = 0; #1;
        check("exp_start", a_busy, 0);
`endif
        step(); check("tc_pulse_end", a_tc, 0);
        a_stop = 1; step(); a_stop = 0;
        a_ldv = 1; a_ldd = 9; step(); a_ldv = 0; #1;
        check("p_ld_q", a_q, 9);
        a_start = 1; step(); a_start = 0; #1;
        check("p_run_q", a_q, 9);
        a_ldv = 1; a_ldd = 1; #1;
        check("p_run_ldr", a_ldr, 0);
        step(); a_ldv = 0; #1;
        check("p_run_ld_ignored", a_q, 8);
        step(); step();
        check("p_q6", a_q, 6);
        a_stop = 1; step(); a_stop = 0; #1;
        check("p_pause_q", a_q, 6);
        check("p_pause_busy", a_busy, 0);
        step(); check("p_hold_q", a_q, 6);
        a_start = 1; step(); a_start = 0; #1;
        check("p_resume_q", a_q, 6);
        check("p_resume_busy", a_busy, 1);
        n = 0;
        while (a_tc !== 1'b1 && n < 40) begin step(); n++; end
        check("p_total_dec", 3 + n, 10);
        a_stop = 1; step(); a_stop = 0;
        a_ldv = 1; a_ldd = 0; step(); a_ldv = 0;
        a_start = 1; step(); a_start = 0; #1;
        check("z_bo", a_bo, 1);
        step(); check("z_one_dec_tc", a_tc, 1);
        a_stop = 1; step(); a_stop = 0;
        a_ldv = 1; a_ldd = 0; step(); a_ldv = 0;
        a_start = 1; step(); a_start = 0; #1;
        check("sr_pre_bo", a_bo, 1);
        sr = 1; step(); sr = 0; #1;
        check("sr_q", a_q, 0);
        check("sr_tc", a_tc, 0);
        check("sr_busy", a_busy, 0);
        check("sr_ldr", a_ldr, 1);
        lo_ldd = 2; hi_ldd = 1; c_ldv = 1; step(); c_ldv = 0;
        c_start = 1; step(); c_start = 0; #1;
        check("c_lo_start", lo_q, 2);
        check("c_hi_start", hi_q, 1);
        step(); step();
        check("c_lo_zero_bo", lo_bo, 1);
        check("c_hi_bo", hi_bo, 0);
        step();
        check("c_lo_wrap", lo_q, 4'hf);
        check("c_hi_dec", hi_q, 0);
        n = 0;
        while (lo_tc !== 1'b1 && n < 40) begin step(); n++; end
        check("c_total_dec", 3 + n, 19);
        check("c_hi_tc", hi_tc, 1);
`ifdef LB_DOWN_TIMER_AUTORELOAD_EN
        check("c_lo_reload", lo_q, 2);
        check("c_hi_reload", hi_q, 1);
        check("c_busy", lo_busy & hi_busy, 1);
        a_ldv = 1; a_ldd = 2; step(); a_ldv = 0;
        a_start = 1; step(); a_start = 0; #1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("ar_q", a_q, (i % 3 == 0) ? 1 : (i % 3 == 1) ? 0 : 2);
            check("ar_tc", a_tc, (i % 3 == 2) ? 1 : 0);
            check("ar_busy", a_busy, 1);
        end
`else
        check("c_lo_q", lo_q, 0);
        check("c_hi_q", hi_q, 0);
        check("c_busy", lo_busy | hi_busy, 0);
        check("c_ldr", lo_ldr & hi_ldr, 1);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
